scan_pattern_engine: RTL and testbench
======================================

# scan_pattern_engine

On-chip scan pattern applier for the s5378_bench scan-wrapped core: replaces simulator-driven load/unload with synthesizable RTL. Streams stimulus into NCHAINS scan chains, gates the core clock for shift and capture, and compares unloaded responses against expected/mask data. Supports single-capture stuck-at and double-pulse launch-off-capture transition/SDD patterns. Sits between a pattern source (BIST ROM or tester FIFO) and the core's test_si*/test_so*/test_se pins.

## Interface
- NCHAINS, 2, number of scan chains
- MAX_LEN, 128, maximum shift cycles per load
- LEN_W, $clog2(MAX_LEN+1), width of shift_len
- FAIL_W, 16, width of miscompare counter (saturating)
- PAT_W, 16, width of pattern counter

- blif_clk_net  in  1  clock
- blif_reset_net  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a pattern when idle
- flush  in  1  sampled with start; 1 = unload-only, no capture
- mode  in  1  sampled with start; 0 = stuck-at (1 capture pulse), 1 = LOC (2 pulses)
- shift_len  in  LEN_W  sampled with start; shift beats this pattern
- si_valid  in  1  stimulus/expect beat valid
- si_ready  out  1  beat accepted when si_valid && si_ready
- si_data  in  NCHAINS  scan-in bit per chain
- exp_data  in  NCHAINS  expected scan-out bit per chain (previous pattern's response)
- exp_mask  in  NCHAINS  1 = compare this bit
- scan_in  out  NCHAINS  to core test_si*
- scan_out  in  NCHAINS  from core test_so*
- scan_en  out  1  to core test_se
- core_clk_en  out  1  clock-gate enable for core clock
- busy  out  1  pattern in progress
- done  out  1  one-cycle pulse at pattern end
- err  out  1  sticky; illegal shift_len seen
- pattern_cnt  out  PAT_W  completed capture patterns
- fail_cnt  out  FAIL_W  total miscompared bits, saturating
- first_fail_pat / first_fail_beat / first_fail_chain  out  PAT_W / LEN_W / $clog2(NCHAINS)  location of first miscompare
- any_fail  out  1  sticky; first_fail_* valid

## Operation
- States: IDLE, SHIFT, SETTLE, CAPTURE, DONE.
- IDLE: si_ready=0, scan_en=0, core_clk_en=0. start latches flush/mode/shift_len. shift_len==0 or >MAX_LEN: set err, go DONE without shifting. Otherwise -> SHIFT. start while busy ignored.
- SHIFT: scan_en=1 (registered), si_ready=1. Per accepted beat: scan_in=si_data, core_clk_en=1 (combinational), compare scan_out vs exp_data under exp_mask. Beat with si_valid=0 is a stall: core_clk_en=0, chains hold. After shift_len beats: flush -> DONE, else -> SETTLE.
- Compare enabled only if a capture pattern has completed since reset (compare_armed); first load never compares.
- Miscompare vector = (scan_out ^ exp_data) & exp_mask; fail_cnt += popcount, saturating at all-ones. First nonzero vector sets any_fail and records first_fail_pat=pattern_cnt-1, beat index (0-based), lowest failing chain.
- SETTLE: scan_en=0, core_clk_en=0, one cycle.
- CAPTURE: core_clk_en=1 for 1 cycle (mode 0) or 2 consecutive cycles (mode 1, launch then capture at speed); scan_en=0.
- DONE: done=1 one cycle; pattern_cnt += 1 (wraps) unless flush or err path; sets compare_armed; -> IDLE.

## Timing
- Reset: all outputs 0, state IDLE, counters cleared, compare_armed=0; reset mid-pattern abandons it with no done pulse.
- start to first si_ready: 1 cycle. Capture pattern length with no stalls: 1 + shift_len + 1 + (1|2) + 1 cycles start-to-done.
- scan_out sampled in the same cycle as the accepted beat, before the core edge it enables.
- busy=1 from cycle after start through DONE inclusive.

## Structure
- Package scan_eng_pkg: state enum, MODE_SA/MODE_LOC constants, popcount function.
- Sub-module scan_miscompare: combinational XOR/mask, popcount, lowest-set-bit index.

## Test plan
- Reset, NCHAINS=2, shift_len=4, mode 0, no stalls -> 4 core_clk_en beats with scan_en=1, 1 SETTLE, 1 capture pulse, done at start+8, pattern_cnt=1, fail_cnt=0 (first load not compared).
- Mode 1, shift_len=3 -> exactly 2 consecutive core_clk_en cycles with scan_en=0; done at start+8.
- Second pattern, exp_data mismatch on chain 1 beat 2, mask=2'b11 -> fail_cnt=1, first_fail_pat=0, beat=2, chain=1; same mismatch masked -> fail_cnt unchanged.
- si_valid deasserted 3 cycles mid-shift -> core_clk_en=0 those cycles, beat count intact, done delayed by 3.
- shift_len=0 -> err=1, done next-but-one cycle, no core_clk_en, pattern_cnt unchanged; flush=1 shift_len=4 -> compares, no capture, pattern_cnt unchanged.
- Reset asserted during CAPTURE -> all outputs 0 immediately, no done; fail_cnt forced to saturate with FAIL_W=4 -> holds at 15.

Source files
------------

// File: rtl/scan_eng_pkg.sv
// scan_eng_pkg: shared state encoding, capture mode constants and popcount helper
package scan_eng_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SETTLE, S_CAPTURE, S_DONE} state_t;
  localparam logic MODE_SA  = 1'b0;
  localparam logic MODE_LOC = 1'b1;
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c = c + {31'b0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/scan_miscompare.sv
// scan_miscompare: masked response compare with bit count and lowest failing chain
module scan_miscompare
  import scan_eng_pkg::*;
#(
  parameter int NCHAINS = 2,
  parameter int CW      = 1,
  parameter int PCW     = 2
) (
  input  logic [NCHAINS-1:0] i_out,
  input  logic [NCHAINS-1:0] i_exp,
  input  logic [NCHAINS-1:0] i_mask,
  output logic [NCHAINS-1:0] o_vec,
  output logic [PCW-1:0]     o_cnt,
  output logic [CW-1:0]      o_low
);
  always_comb begin
    o_vec = (i_out ^ i_exp) & i_mask;
    o_cnt = PCW'(popcount(32'(o_vec)));
    o_low = '0;
    for (int i = NCHAINS - 1; i >= 0; i--) if (o_vec[i]) o_low = CW'(i);
  end
endmodule

// File: rtl/scan_pattern_engine.sv
// scan_pattern_engine: streams scan loads, gates core clock for shift/capture and
// scores unloaded responses against expected data
module scan_pattern_engine
  import scan_eng_pkg::*;
#(
  parameter int NCHAINS = 2,
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int FAIL_W  = 16,
  parameter int PAT_W   = 16,
  localparam int CW     = NCHAINS > 1 ? $clog2(NCHAINS) : 1,
  localparam int PCW    = $clog2(NCHAINS + 1)
) (
  input  logic               blif_clk_net,
  input  logic               blif_reset_net,
  input  logic               start,
  input  logic               flush,
  input  logic               mode,
  input  logic [LEN_W-1:0]   shift_len,
  input  logic               si_valid,
  output logic               si_ready,
  input  logic [NCHAINS-1:0] si_data,
  input  logic [NCHAINS-1:0] exp_data,
  input  logic [NCHAINS-1:0] exp_mask,
  output logic [NCHAINS-1:0] scan_in,
  input  logic [NCHAINS-1:0] scan_out,
  output logic               scan_en,
  output logic               core_clk_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PAT_W-1:0]   pattern_cnt,
  output logic [FAIL_W-1:0]  fail_cnt,
  output logic [PAT_W-1:0]   first_fail_pat,
  output logic [LEN_W-1:0]   first_fail_beat,
  output logic [CW-1:0]      first_fail_chain,
  output logic               any_fail
);
  state_t             r_state, w_next;
  logic               r_flush, r_mode, r_cap, r_bad, r_armed, r_scan_en, r_done, r_err, r_any;
  logic [LEN_W-1:0]   r_len, r_beat, r_ffb;
  logic [PAT_W-1:0]   r_pat, r_ffp;
  logic [FAIL_W-1:0]  r_fail;
  logic [CW-1:0]      r_ffc, w_low;
  logic [NCHAINS-1:0] w_vec;
  logic [PCW-1:0]     w_cnt;
  logic [FAIL_W:0]    w_sum;
  logic               w_acc, w_last, w_len_bad, w_cmp, w_miss;

  assign w_len_bad   = shift_len == '0 || shift_len > LEN_W'(MAX_LEN);
  assign w_acc       = r_state == S_SHIFT && si_valid;
  assign w_last      = w_acc && r_beat == r_len - LEN_W'(1);
  assign w_cmp       = w_acc && r_armed;
  assign w_miss      = w_cmp && |w_vec;
  assign w_sum       = {1'b0, r_fail} + (FAIL_W + 1)'(w_cnt);
  assign si_ready    = r_state == S_SHIFT;
  assign scan_in     = si_ready ? si_data : '0;
  assign core_clk_en = w_acc || r_state == S_CAPTURE;
  assign busy        = r_state != S_IDLE;
  assign scan_en     = r_scan_en;
  assign done        = r_done;
  assign err         = r_err;
  assign pattern_cnt = r_pat;
  assign fail_cnt    = r_fail;
  assign first_fail_pat   = r_ffp;
  assign first_fail_beat  = r_ffb;
  assign first_fail_chain = r_ffc;
  assign any_fail    = r_any;

  scan_miscompare #(.NCHAINS(NCHAINS), .CW(CW), .PCW(PCW)) u_cmp (
    .i_out (scan_out),
    .i_exp (exp_data),
    .i_mask(exp_mask),
    .o_vec (w_vec),
    .o_cnt (w_cnt),
    .o_low (w_low)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = w_len_bad ? S_DONE : S_SHIFT;
      S_SHIFT:   if (w_last) w_next = r_flush ? S_DONE : S_SETTLE;
      S_SETTLE:  w_next = S_CAPTURE;
      S_CAPTURE: if (r_mode == MODE_SA || r_cap) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      r_state   <= S_IDLE;
      r_flush   <= 1'b0;
      r_mode    <= 1'b0;
      r_cap     <= 1'b0;
      r_bad     <= 1'b0;
      r_armed   <= 1'b0;
      r_scan_en <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_any     <= 1'b0;
      r_len     <= '0;
      r_beat    <= '0;
      r_ffb     <= '0;
      r_pat     <= '0;
      r_ffp     <= '0;
      r_fail    <= '0;
      r_ffc     <= '0;
    end else begin
      r_state   <= w_next;
      r_scan_en <= w_next == S_SHIFT;
      r_done    <= r_state == S_DONE;
      if (r_state == S_IDLE && start) begin
        r_flush <= flush;
        r_mode  <= mode;
        r_len   <= shift_len;
        r_beat  <= '0;
        r_cap   <= 1'b0;
        r_bad   <= w_len_bad;
        if (w_len_bad) r_err <= 1'b1;
      end
      if (w_acc) r_beat <= r_beat + LEN_W'(1);
      if (r_state == S_CAPTURE) r_cap <= 1'b1;
      // only a completed capture leaves meaningful responses in the chains
      if (r_state == S_DONE && !r_flush && !r_bad) begin
        r_pat   <= r_pat + PAT_W'(1);
        r_armed <= 1'b1;
      end
      if (w_cmp) r_fail <= w_sum[FAIL_W] ? '1 : w_sum[FAIL_W-1:0];
      if (w_miss && !r_any) begin
        r_any <= 1'b1;
        r_ffp <= r_pat - PAT_W'(1);
        r_ffb <= r_beat;
        r_ffc <= w_low;
      end
    end
  end
endmodule

// File: tb/tb_scan_pattern_engine.sv
// tb_scan_pattern_engine: directed checks of shift/capture timing, compare and error paths
module tb_scan_pattern_engine;
  localparam int N = 2, ML = 128, LW = 8, FW = 4, PW = 16;
  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 0, flush = 0, mode = 0, si_valid = 0;
  logic [LW-1:0] shift_len = '0;
  logic [N-1:0]  si_data = '0, exp_data = '0, exp_mask = '0, scan_out = '0;
  logic          si_ready, scan_en, core_clk_en, busy, done, err, any_fail;
  logic [N-1:0]  scan_in;
  logic [PW-1:0] pattern_cnt, first_fail_pat;
  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] first_fail_beat;
  logic [0:0]    first_fail_chain;
  int checks = 0, errors = 0;
  int dc, sc, cc, span, leak, sib, dseen;

  scan_pattern_engine #(.NCHAINS(N), .MAX_LEN(ML), .LEN_W(LW), .FAIL_W(FW), .PAT_W(PW)) dut (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .flush(flush), .mode(mode),
    .shift_len(shift_len), .si_valid(si_valid), .si_ready(si_ready), .si_data(si_data),
    .exp_data(exp_data), .exp_mask(exp_mask), .scan_in(scan_in), .scan_out(scan_out),
    .scan_en(scan_en), .core_clk_en(core_clk_en), .busy(busy), .done(done), .err(err),
    .pattern_cnt(pattern_cnt), .fail_cnt(fail_cnt), .first_fail_pat(first_fail_pat),
    .first_fail_beat(first_fail_beat), .first_fail_chain(first_fail_chain), .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mis_beat < 0 flips exp_data on every beat; stall_at < 0 means no stall
  task automatic run(input logic fl, input logic md, input int len, input int stall_at,
                     input int stall_n, input int mis_beat, input logic [1:0] mis_vec,
                     input logic [1:0] mask, output int o_dc, output int o_sc, output int o_cc,
                     output int o_span, output int o_leak, output int o_sib);
    int b, st, fc, lc;
    b = 0; st = stall_n; fc = -1; lc = -1;
    o_dc = -1; o_sc = 0; o_cc = 0; o_leak = 0; o_sib = 0;
    @(posedge clk); #1;
    start = 1; flush = fl; mode = md; shift_len = LW'(len); si_valid = 0;
    for (int k = 1; k <= 200 && o_dc < 0; k++) begin
      @(posedge clk); #1;
      start = 0;
      si_valid = !(b == stall_at && st > 0);
      si_data = 2'(b + 1);
      scan_out = 2'(b * 3);
      exp_data = scan_out ^ ((mis_beat < 0 || b == mis_beat) ? mis_vec : 2'b00);
      exp_mask = mask;
      #1;
      if (!si_valid && scan_en) begin st--; if (core_clk_en) o_leak++; end
      if (si_ready && scan_in !== si_data) o_sib++;
      if (core_clk_en && scan_en) o_sc++;
      if (core_clk_en && !scan_en) begin o_cc++; if (fc < 0) fc = k; lc = k; end
      if (si_valid && si_ready) b++;
      if (done) o_dc = k;
    end
    o_span = o_cc > 0 ? lc - fc + 1 : 0;
    si_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {si_ready, scan_en, core_clk_en, done, err, any_fail, scan_in}, 0);
    chk("rst_cnts", {pattern_cnt, fail_cnt}, 0);
    rst = 0;
    run(0, 0, 4, -1, 0, -1, 2'b11, 2'b11, dc, sc, cc, span, leak, sib);
    chk("A_done", dc, 8); chk("A_shift", sc, 4); chk("A_cap", cc, 1); chk("A_si", sib, 0);
    chk("A_pat", pattern_cnt, 1); chk("A_fail", fail_cnt, 0); chk("A_any", any_fail, 0);
    run(0, 0, 4, -1, 0, 2, 2'b10, 2'b11, dc, sc, cc, span, leak, sib);
    chk("B_fail", fail_cnt, 1); chk("B_any", any_fail, 1); chk("B_ffpat", first_fail_pat, 0);
    chk("B_ffbeat", first_fail_beat, 2); chk("B_ffchain", first_fail_chain, 1);
    chk("B_pat", pattern_cnt, 2);
    run(0, 1, 3, -1, 0, 2, 2'b10, 2'b01, dc, sc, cc, span, leak, sib);
    chk("C_done", dc, 8); chk("C_shift", sc, 3); chk("C_cap", cc, 2); chk("C_span", span, 2);
    chk("C_fail", fail_cnt, 1); chk("C_pat", pattern_cnt, 3);
    run(0, 0, 4, 2, 3, -1, 2'b00, 2'b11, dc, sc, cc, span, leak, sib);
    chk("D_done", dc, 11); chk("D_shift", sc, 4); chk("D_leak", leak, 0);
    chk("D_pat", pattern_cnt, 4);
    run(0, 0, 0, -1, 0, -1, 2'b00, 2'b11, dc, sc, cc, span, leak, sib);
    chk("E_done", dc, 2); chk("E_clk", sc + cc, 0); chk("E_err", err, 1);
    chk("E_pat", pattern_cnt, 4);
    run(1, 0, 4, -1, 0, 0, 2'b01, 2'b11, dc, sc, cc, span, leak, sib);
    chk("F_done", dc, 6); chk("F_shift", sc, 4); chk("F_cap", cc, 0); chk("F_fail", fail_cnt, 2);
    chk("F_pat", pattern_cnt, 4); chk("F_ffbeat", first_fail_beat, 2); chk("F_err", err, 1);
    run(0, 0, 8, -1, 0, -1, 2'b11, 2'b11, dc, sc, cc, span, leak, sib);
    chk("G_done", dc, 12); chk("G_sat", fail_cnt, 15); chk("G_pat", pattern_cnt, 5);
    @(posedge clk); #1;
    start = 1; mode = 1; flush = 0; shift_len = 2;
    @(posedge clk); #1;
    start = 0; si_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("H_incap", {core_clk_en, scan_en}, 2'b10);
    rst = 1;
    #1;
    chk("H_rst_outs", {core_clk_en, scan_en, si_ready, busy, done, err, any_fail, scan_in}, 0);
    chk("H_rst_cnts", {pattern_cnt, fail_cnt}, 0);
    si_valid = 0; dseen = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dseen++; end
    rst = 0;
    repeat (3) begin @(posedge clk); #1; if (done || busy) dseen++; end
    chk("H_nodone", dseen, 0);
    run(0, 0, 4, -1, 0, -1, 2'b11, 2'b11, dc, sc, cc, span, leak, sib);
    chk("I_done", dc, 8); chk("I_fail", fail_cnt, 0); chk("I_pat", pattern_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
